// File: rtl/soml_nested_addr_gen.sv
// soml_nested_addr_gen
//   3-level nested address generator for the SOML decoder. It sweeps column-of-S (inner,
//   fastest), row-of-H (middle) and symbol index Si (outer, slowest). The loop bounds are
//   latched at start. A valid/ready handshake applies backpressure, and the block raises
//   per-level last flags and a one-cycle done pulse after the final beat is accepted.
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   start, abort      : sequencer control (start is sampled only in IDLE; abort wins)
//   cfg_*_max         : last index of each loop level (level size = value + 1)
//   addr_ready        : consumer accepts the current beat
//   addr_valid, addr_*: registered address beat
//   last_col/row/all  : beat is the last of the inner / middle / whole sweep
//   busy, done        : sweep running / one-cycle end-of-sweep pulse
module soml_nested_addr_gen #(
  parameter int unsigned COL_W = 2,
  parameter int unsigned ROW_W = 2,
  parameter int unsigned SI_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [COL_W-1:0] cfg_col_max,
  input  logic [ROW_W-1:0] cfg_row_max,
  input  logic [SI_W-1:0]  cfg_si_max,
  input  logic             addr_ready,
  output logic             addr_valid,
  output logic [COL_W-1:0] addr_colS,
  output logic [ROW_W-1:0] addr_rowH,
  output logic [SI_W-1:0]  addr_Si,
  output logic             last_col,
  output logic             last_row,
  output logic             last_all,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, col_max_q, col_max_d;
  logic [ROW_W-1:0] row_q, row_d, row_max_q, row_max_d;
  logic [SI_W-1:0]  si_q, si_d, si_max_q, si_max_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             col_hit, row_hit, si_hit, accept;

  assign col_hit = (col_q == col_max_q);
  assign row_hit = (row_q == row_max_q);
  assign si_hit  = (si_q == si_max_q);
  assign accept  = valid_q && addr_ready;

  // Outputs are functions of registers only; valid qualifies the last flags.
  assign addr_valid = valid_q;
  assign addr_colS  = col_q;
  assign addr_rowH  = row_q;
  assign addr_Si    = si_q;
  assign last_col   = valid_q && col_hit;
  assign last_row   = last_col && row_hit;
  assign last_all   = last_row && si_hit;
  assign busy       = (state_q == StRun);
  assign done       = done_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    si_d      = si_q;
    col_max_d = col_max_q;
    row_max_d = row_max_q;
    si_max_d  = si_max_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          col_max_d = cfg_col_max;
          row_max_d = cfg_row_max;
          si_max_d  = cfg_si_max;
          col_d     = '0;
          row_d     = '0;
          si_d      = '0;
          valid_d   = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (abort) begin
          col_d   = '0;
          row_d   = '0;
          si_d    = '0;
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (accept) begin
          if (last_all) begin
            col_d   = '0;
            row_d   = '0;
            si_d    = '0;
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else if (col_hit) begin
            col_d = '0;
            if (row_hit) begin
              row_d = '0;
              si_d  = si_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      si_q      <= '0;
      col_max_q <= '0;
      row_max_q <= '0;
      si_max_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      si_q      <= si_d;
      col_max_q <= col_max_d;
      row_max_q <= row_max_d;
      si_max_q  <= si_max_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_soml_nested_addr_gen.sv
// Bench for soml_nested_addr_gen: table of sweeps driven through one task, expected beats
// queued at start and popped on each accepted beat, plus hand sequences for back-to-back
// frames, reset mid-run and abort/start priority.
module tb_soml_nested_addr_gen;
  localparam int unsigned COL_W = 2;
  localparam int unsigned ROW_W = 2;
  localparam int unsigned SI_W  = 4;

  logic             clk = 1'b0;
  logic             rst, start, abort, addr_ready;
  logic [COL_W-1:0] cfg_col_max;
  logic [ROW_W-1:0] cfg_row_max;
  logic [SI_W-1:0]  cfg_si_max;
  logic             addr_valid, last_col, last_row, last_all, busy, done;
  logic [COL_W-1:0] addr_colS;
  logic [ROW_W-1:0] addr_rowH;
  logic [SI_W-1:0]  addr_Si;

  soml_nested_addr_gen #(.COL_W(COL_W), .ROW_W(ROW_W), .SI_W(SI_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_col_max(cfg_col_max), .cfg_row_max(cfg_row_max), .cfg_si_max(cfg_si_max),
    .addr_ready(addr_ready), .addr_valid(addr_valid),
    .addr_colS(addr_colS), .addr_rowH(addr_rowH), .addr_Si(addr_Si),
    .last_col(last_col), .last_row(last_row), .last_all(last_all),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COL_W-1:0] c;
    logic [ROW_W-1:0] r;
    logic [SI_W-1:0]  s;
    logic             lc, lr, la;
  } beat_t;

  typedef struct {
    int cm, rm, sm;
    bit rnd;       // random 50% ready
    bit chg;       // scramble cfg and toggle start while running
    int abort_at;  // accepted-beat count at which abort is raised, -1 for none
    int beats;     // expected accepted beats
  } vec_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return {17'd0, addr_valid, busy, done, last_col, last_row, last_all,
            addr_colS, addr_rowH, addr_Si};
  endfunction

  task automatic chk_idle(input string name);
    chk(name, outs_vec(), 32'd0);
  endtask

  task automatic run_sweep(input int cm, input int rm, input int sm, input bit rnd,
                           input bit chg, input bit pre_started, input int abort_at,
                           input int beats, input bit leave_done, input string tag);
    int          acc = 0;
    int          cyc = 0;
    bit          prev_stall = 0;
    bit          aborted = 0;
    logic [31:0] prev = '0;
    beat_t       e;
    if (!pre_started) begin
      cfg_col_max = COL_W'(cm);
      cfg_row_max = ROW_W'(rm);
      cfg_si_max  = SI_W'(sm);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int s = 0; s <= sm; s++)
      for (int r = 0; r <= rm; r++)
        for (int c = 0; c <= cm; c++) begin
          e.c = COL_W'(c); e.r = ROW_W'(r); e.s = SI_W'(s);
          e.lc = (c == cm); e.lr = (c == cm) && (r == rm);
          e.la = (c == cm) && (r == rm) && (s == sm);
          q.push_back(e);
        end
    while (q.size() > 0 && cyc < 2000) begin
      if (prev_stall) chk({tag, " stall_stable"}, outs_vec(), prev);
      chk({tag, " busy_run"}, {31'd0, busy}, 32'd1);
      chk({tag, " done_run"}, {31'd0, done}, 32'd0);
      addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (chg) begin
        cfg_col_max = COL_W'($urandom);
        cfg_row_max = ROW_W'($urandom);
        cfg_si_max  = SI_W'($urandom);
        start       = 1'($urandom_range(0, 1));
      end
      if (abort_at >= 0 && acc == abort_at) abort = 1'b1;
      if (addr_valid && addr_ready) begin
        e = q.pop_front();
        chk({tag, " beat"}, {26'd0, addr_colS, addr_rowH, addr_Si},
            {26'd0, e.c, e.r, e.s});
        chk({tag, " last"}, {29'd0, last_col, last_row, last_all}, {29'd0, e.lc, e.lr, e.la});
        acc++;
      end else if (!addr_valid) begin
        chk({tag, " valid_run"}, 32'd0, 32'd1);
      end
      prev_stall = addr_valid && !addr_ready;
      prev = outs_vec();
      @(negedge clk);
      cyc++;
      if (abort) begin
        abort = 1'b0;
        start = 1'b0;
        aborted = 1;
        chk_idle({tag, " abort_idle"});
        q.delete();
      end
    end
    start = 1'b0;
    addr_ready = 1'b1;
    if (q.size() > 0) begin
      chk({tag, " timeout"}, q.size(), 32'd0);
      q.delete();
    end
    chk({tag, " beat_count"}, acc, beats);
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk_idle({tag, " no_done_after_abort"});
      end
    end else begin
      chk({tag, " done_cycle"}, outs_vec(), 32'h2000 >> 6 << 6 & 32'd0 | (32'd1 << 11));
      if (!leave_done) begin
        @(negedge clk);
        chk_idle({tag, " done_one_cycle"});
      end
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{cm: 1, rm: 3, sm: 15, rnd: 0, chg: 0, abort_at: -1, beats: 128};
    vecs[1] = '{cm: 1, rm: 3, sm: 15, rnd: 1, chg: 0, abort_at: -1, beats: 128};
    vecs[2] = '{cm: 0, rm: 0, sm: 0,  rnd: 0, chg: 0, abort_at: -1, beats: 1};
    vecs[3] = '{cm: 1, rm: 2, sm: 3,  rnd: 1, chg: 1, abort_at: -1, beats: 24};
    vecs[4] = '{cm: 1, rm: 3, sm: 15, rnd: 0, chg: 0, abort_at: 40, beats: 41};

    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    cfg_col_max = '0; cfg_row_max = '0; cfg_si_max = '0;
    repeat (2) @(negedge clk);
    chk_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle_after_reset");

    for (int i = 0; i < 5; i++)
      run_sweep(vecs[i].cm, vecs[i].rm, vecs[i].sm, vecs[i].rnd, vecs[i].chg, 1'b0,
                vecs[i].abort_at, vecs[i].beats, 1'b0, $sformatf("vec%0d", i));

    // Back-to-back frames: start raised during the done cycle.
    run_sweep(1, 0, 1, 1'b0, 1'b0, 1'b0, -1, 4, 1'b1, "b2b_first");
    cfg_col_max = 2'd0; cfg_row_max = 2'd1; cfg_si_max = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_first_beat", {29'd0, addr_valid, busy, done}, 32'b110);
    run_sweep(0, 1, 0, 1'b0, 1'b0, 1'b1, -1, 2, 1'b0, "b2b_second");

    // Reset in the middle of a sweep.
    cfg_col_max = 2'd1; cfg_row_max = 2'd3; cfg_si_max = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_idle("rst_mid_run");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("idle_after_mid_rst");
    run_sweep(1, 1, 1, 1'b0, 1'b0, 1'b0, -1, 8, 1'b0, "after_rst");

    // abort has priority over start in IDLE.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_idle("abort_beats_start");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
